// File: rtl/gpu_instruction_queue.sv
// gpu_instruction_queue
// Buffers 35-bit GPU instructions between the instruction source and the GPU.
// A DEPTH-entry circular store feeds a single registered output stage that is
// handed to the GPU with a valid/accept handshake.
//
// Build option: define GPU_INSTRUCTION_QUEUE_FENCE_EN to make FENCE entries
// (opcode bits == FENCE_OPCODE) hold issue until the next VGA frame start.
// Without it FENCE entries are ordinary instructions and VS is unused.
//
// Ports:
//   Clk               system clock, rising edge
//   Reset             asynchronous, active-high reset
//   WriteInstruction  instruction from the producer
//   WriteValid        producer offers WriteInstruction
//   WriteReady        queue can accept a write this cycle (Count != DEPTH)
//   VS                vertical sync, active-low
//   Instruction       registered instruction to the GPU
//   InstructionValid  Instruction holds a valid entry
//   InstructionAccept GPU consumes Instruction this cycle
//   Count             entries in storage, excluding the output register
//   Stalled           waiting for a frame start after a FENCE
//   Overflow          sticky: a write was offered while WriteReady=0
module gpu_instruction_queue #(
  parameter int          INSTR_WIDTH  = 35,
  parameter int          DEPTH        = 16,
  parameter int          ADDR_WIDTH   = 4,
  parameter logic [2:0]  FENCE_OPCODE = 3'b111
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [INSTR_WIDTH-1:0] WriteInstruction,
  input  logic                   WriteValid,
  output logic                   WriteReady,
  input  logic                   VS,
  output logic [INSTR_WIDTH-1:0] Instruction,
  output logic                   InstructionValid,
  input  logic                   InstructionAccept,
  output logic [ADDR_WIDTH:0]    Count,
  output logic                   Stalled,
  output logic                   Overflow
);

`ifdef GPU_INSTRUCTION_QUEUE_FENCE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, PRESENT = 2'd1, WAIT_FRAME = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, PRESENT = 2'd1} state_t;
`endif

  logic [INSTR_WIDTH-1:0] mem_r [DEPTH];
  logic [ADDR_WIDTH-1:0]  wptr_r, rptr_r;
  logic [ADDR_WIDTH:0]    count_r;
  logic [INSTR_WIDTH-1:0] instr_r, instr_nxt_s;
  logic                   valid_r, valid_nxt_s;
  logic                   stalled_r, stalled_nxt_s;
  logic                   overflow_r;
  state_t                 state_r, state_nxt_s;
  logic                   full_s, empty_s, write_s, pop_s;
  logic [INSTR_WIDTH-1:0] head_s;
  logic                   head_fence_s;
  logic                   frame_edge_s;

  assign full_s     = (count_r == (ADDR_WIDTH+1)'(DEPTH));
  assign empty_s    = (count_r == (ADDR_WIDTH+1)'(0));
  assign write_s    = WriteValid && !full_s;
  assign head_s     = mem_r[rptr_r];

`ifdef GPU_INSTRUCTION_QUEUE_FENCE_EN
  logic vs_prev_r;

  assign head_fence_s = (head_s[INSTR_WIDTH-1 -: 3] == FENCE_OPCODE);
  // Falling edge of VS: high on the previous edge, low on this one.
  assign frame_edge_s = vs_prev_r && !VS;

  // One-deep VS history for frame-edge detection.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vs_prev_r <= 1'b1;
    end else begin
      vs_prev_r <= VS;
    end
  end
`else
  logic unused_vs_s;

  assign head_fence_s = 1'b0;
  assign frame_edge_s = 1'b0;
  assign unused_vs_s  = VS;
`endif

  // Next-state and output-stage decode; pops only from IDLE or on an accept.
  always_comb begin
    pop_s         = 1'b0;
    state_nxt_s   = state_r;
    instr_nxt_s   = instr_r;
    valid_nxt_s   = valid_r;
    stalled_nxt_s = stalled_r;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          pop_s = 1'b1;
        end else begin
          pop_s = 1'b0;
        end
      end
      PRESENT: begin
        if (InstructionAccept && !empty_s) begin
          pop_s = 1'b1;
        end else if (InstructionAccept) begin
          valid_nxt_s = 1'b0;
          state_nxt_s = IDLE;
        end else begin
          pop_s = 1'b0;
        end
      end
`ifdef GPU_INSTRUCTION_QUEUE_FENCE_EN
      WAIT_FRAME: begin
        if (frame_edge_s) begin
          stalled_nxt_s = 1'b0;
          state_nxt_s   = IDLE;
        end else begin
          stalled_nxt_s = 1'b1;
        end
      end
`endif
      default: begin
        valid_nxt_s   = 1'b0;
        stalled_nxt_s = 1'b0;
        state_nxt_s   = IDLE;
      end
    endcase

    // A popped FENCE is swallowed; anything else becomes the presented entry.
    if (pop_s && head_fence_s) begin
`ifdef GPU_INSTRUCTION_QUEUE_FENCE_EN
      valid_nxt_s   = 1'b0;
      stalled_nxt_s = 1'b1;
      state_nxt_s   = WAIT_FRAME;
`endif
    end else if (pop_s) begin
      instr_nxt_s = head_s;
      valid_nxt_s = 1'b1;
      state_nxt_s = PRESENT;
    end else begin
      instr_nxt_s = instr_nxt_s;
    end
  end

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge Clk) begin
    if (write_s) begin
      mem_r[wptr_r] <= WriteInstruction;
    end
  end

  // Pointers, occupancy, output stage, FSM and sticky overflow.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wptr_r     <= '0;
      rptr_r     <= '0;
      count_r    <= '0;
      instr_r    <= '0;
      valid_r    <= 1'b0;
      stalled_r  <= 1'b0;
      overflow_r <= 1'b0;
      state_r    <= IDLE;
    end else begin
      if (write_s) begin
        wptr_r <= wptr_r + ADDR_WIDTH'(1);
      end
      if (pop_s) begin
        rptr_r <= rptr_r + ADDR_WIDTH'(1);
      end
      if (write_s && !pop_s) begin
        count_r <= count_r + (ADDR_WIDTH+1)'(1);
      end else if (pop_s && !write_s) begin
        count_r <= count_r - (ADDR_WIDTH+1)'(1);
      end
      if (WriteValid && full_s) begin
        overflow_r <= 1'b1;
      end
      instr_r   <= instr_nxt_s;
      valid_r   <= valid_nxt_s;
      stalled_r <= stalled_nxt_s;
      state_r   <= state_nxt_s;
    end
  end

  assign WriteReady       = !full_s;
  assign Instruction      = instr_r;
  assign InstructionValid = valid_r;
  assign Count            = count_r;
  assign Stalled          = stalled_r;
  assign Overflow         = overflow_r;

endmodule

// File: tb/tb_gpu_instruction_queue.sv
// Directed self-checking bench for gpu_instruction_queue.
module tb_gpu_instruction_queue;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [34:0] WriteInstruction = 35'h0;
  logic        WriteValid = 1'b0;
  logic        WriteReady;
  logic        VS = 1'b1;
  logic [34:0] Instruction;
  logic        InstructionValid;
  logic        InstructionAccept = 1'b0;
  logic [4:0]  Count;
  logic        Stalled;
  logic        Overflow;

  int compared = 0;
  int mismatched = 0;

  gpu_instruction_queue dut (
    .Clk(Clk), .Reset(Reset),
    .WriteInstruction(WriteInstruction), .WriteValid(WriteValid), .WriteReady(WriteReady),
    .VS(VS),
    .Instruction(Instruction), .InstructionValid(InstructionValid),
    .InstructionAccept(InstructionAccept),
    .Count(Count), .Stalled(Stalled), .Overflow(Overflow)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic apply_reset();
    WriteValid = 1'b0;
    InstructionAccept = 1'b0;
    VS = 1'b1;
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic write_word(input logic [34:0] d);
    WriteInstruction = d;
    WriteValid = 1'b1;
    tick();
    WriteValid = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    compared++; if (Instruction !== 35'h0) begin mismatched++; $display("FAIL reset_instr: got %h want 0", Instruction); end
    compared++; if (InstructionValid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b want 0", InstructionValid); end
    compared++; if (Count !== 5'd0) begin mismatched++; $display("FAIL reset_count: got %0d want 0", Count); end
    compared++; if (Stalled !== 1'b0) begin mismatched++; $display("FAIL reset_stalled: got %b want 0", Stalled); end
    compared++; if (Overflow !== 1'b0) begin mismatched++; $display("FAIL reset_overflow: got %b want 0", Overflow); end
    compared++; if (WriteReady !== 1'b1) begin mismatched++; $display("FAIL reset_wready: got %b want 1", WriteReady); end
  endtask

  task automatic test_single();
    apply_reset();
    write_word(35'h000000001);
    compared++; if (InstructionValid !== 1'b0 || Count !== 5'd1) begin mismatched++; $display("FAIL single_edge1: valid %b count %0d want 0/1", InstructionValid, Count); end
    tick();
    for (int i = 0; i < 10; i++) begin
      compared++;
      if (InstructionValid !== 1'b1 || Instruction !== 35'h000000001 || Count !== 5'd0) begin
        mismatched++; $display("FAIL single_hold%0d: valid %b instr %h count %0d want 1/000000001/0", i, InstructionValid, Instruction, Count);
      end
      tick();
    end
    InstructionAccept = 1'b1;
    tick();
    InstructionAccept = 1'b0;
    compared++; if (InstructionValid !== 1'b0) begin mismatched++; $display("FAIL single_accept: valid %b want 0", InstructionValid); end
  endtask

  task automatic test_fill_overflow();
    apply_reset();
    for (int k = 1; k <= 17; k++) write_word(35'(k));
    compared++; if (Count !== 5'd16) begin mismatched++; $display("FAIL fill_count: got %0d want 16", Count); end
    compared++; if (WriteReady !== 1'b0) begin mismatched++; $display("FAIL fill_wready: got %b want 0", WriteReady); end
    compared++; if (Instruction !== 35'h1 || InstructionValid !== 1'b1) begin mismatched++; $display("FAIL fill_head: got %h/%b want 1/1", Instruction, InstructionValid); end
    compared++; if (Overflow !== 1'b0) begin mismatched++; $display("FAIL fill_no_ovf: got %b want 0", Overflow); end
    write_word(35'h12);
    compared++; if (Overflow !== 1'b1 || Count !== 5'd16) begin mismatched++; $display("FAIL ovf_set: ovf %b count %0d want 1/16", Overflow, Count); end
    InstructionAccept = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      compared++;
      if (InstructionValid !== 1'b1 || Instruction !== 35'(k)) begin
        mismatched++; $display("FAIL drain%0d: got %h/%b want %h/1", k, Instruction, InstructionValid, 35'(k));
      end
      tick();
    end
    InstructionAccept = 1'b0;
    compared++; if (InstructionValid !== 1'b0 || Count !== 5'd0) begin mismatched++; $display("FAIL drain_end: valid %b count %0d want 0/0", InstructionValid, Count); end
    compared++; if (Overflow !== 1'b1) begin mismatched++; $display("FAIL ovf_sticky: got %b want 1", Overflow); end
  endtask

  task automatic test_stream();
    apply_reset();
    for (int k = 1; k <= 8; k++) write_word(35'(k));
    InstructionAccept = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      compared++;
      if (InstructionValid !== 1'b1 || Instruction !== 35'(k)) begin
        mismatched++; $display("FAIL stream%0d: got %h/%b want %h/1", k, Instruction, InstructionValid, 35'(k));
      end
      tick();
    end
    InstructionAccept = 1'b0;
    compared++; if (InstructionValid !== 1'b0 || Count !== 5'd0) begin mismatched++; $display("FAIL stream_end: valid %b count %0d want 0/0", InstructionValid, Count); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int k = 'h21; k <= 'h24; k++) write_word(35'(k));
    compared++; if (Count !== 5'd3 || Instruction !== 35'h21) begin mismatched++; $display("FAIL b2b_setup: count %0d instr %h want 3/21", Count, Instruction); end
    InstructionAccept = 1'b1;
    write_word(35'h25);
    compared++; if (Count !== 5'd3 || Instruction !== 35'h22) begin mismatched++; $display("FAIL b2b_1: count %0d instr %h want 3/22", Count, Instruction); end
    write_word(35'h26);
    compared++; if (Count !== 5'd3 || Instruction !== 35'h23) begin mismatched++; $display("FAIL b2b_2: count %0d instr %h want 3/23", Count, Instruction); end
    for (int k = 'h24; k <= 'h26; k++) begin
      tick();
      compared++;
      if (InstructionValid !== 1'b1 || Instruction !== 35'(k)) begin
        mismatched++; $display("FAIL b2b_order%0h: got %h/%b want %h/1", k, Instruction, InstructionValid, 35'(k));
      end
    end
    tick();
    InstructionAccept = 1'b0;
    compared++; if (InstructionValid !== 1'b0 || Count !== 5'd0 || Overflow !== 1'b0) begin mismatched++; $display("FAIL b2b_end: valid %b count %0d ovf %b want 0/0/0", InstructionValid, Count, Overflow); end
  endtask

  task automatic test_fence();
    apply_reset();
    InstructionAccept = 1'b1;
    write_word(35'h1);
    write_word(35'h700000000);
    compared++; if (InstructionValid !== 1'b1 || Instruction !== 35'h1) begin mismatched++; $display("FAIL fence_first: got %h/%b want 1/1", Instruction, InstructionValid); end
`ifdef GPU_INSTRUCTION_QUEUE_FENCE_EN
    write_word(35'h2);
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (Stalled !== 1'b1 || InstructionValid !== 1'b0 || Count !== 5'd1) begin
        mismatched++; $display("FAIL fence_stall%0d: stalled %b valid %b count %0d want 1/0/1", i, Stalled, InstructionValid, Count);
      end
      tick();
    end
    InstructionAccept = 1'b0;
    VS = 1'b0;
    tick();
    compared++; if (Stalled !== 1'b0 || InstructionValid !== 1'b0) begin mismatched++; $display("FAIL fence_edge1: stalled %b valid %b want 0/0", Stalled, InstructionValid); end
    tick();
    compared++; if (InstructionValid !== 1'b1 || Instruction !== 35'h2) begin mismatched++; $display("FAIL fence_release: got %h/%b want 2/1", Instruction, InstructionValid); end
`else
    tick();
    compared++; if (InstructionValid !== 1'b1 || Instruction !== 35'h700000000 || Stalled !== 1'b0) begin mismatched++; $display("FAIL fence_plain: got %h/%b stalled %b want 700000000/1/0", Instruction, InstructionValid, Stalled); end
`endif
    InstructionAccept = 1'b0;
    VS = 1'b1;
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    for (int k = 1; k <= 6; k++) write_word(35'(k + 'h40));
    compared++; if (Count !== 5'd5 || InstructionValid !== 1'b1) begin mismatched++; $display("FAIL mid_setup: count %0d valid %b want 5/1", Count, InstructionValid); end
    #2 Reset = 1'b1;
    #1;
    compared++; if (InstructionValid !== 1'b0 || Count !== 5'd0 || Instruction !== 35'h0 || WriteReady !== 1'b1) begin
      mismatched++; $display("FAIL mid_async: valid %b count %0d instr %h wready %b want 0/0/0/1", InstructionValid, Count, Instruction, WriteReady);
    end
    @(negedge Clk);
    Reset = 1'b0;
    write_word(35'h55);
    compared++; if (Count !== 5'd1) begin mismatched++; $display("FAIL mid_write: count %0d want 1", Count); end
    tick();
    compared++; if (InstructionValid !== 1'b1 || Instruction !== 35'h55 || Count !== 5'd0) begin mismatched++; $display("FAIL mid_sole: got %h/%b count %0d want 55/1/0", Instruction, InstructionValid, Count); end
    InstructionAccept = 1'b1;
    tick();
    InstructionAccept = 1'b0;
    compared++; if (InstructionValid !== 1'b0) begin mismatched++; $display("FAIL mid_empty: valid %b want 0", InstructionValid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_stream();
    test_back_to_back();
    test_fence();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
